spi_slave: RTL

SPI mode-0 peripheral: the responder end of the link driven by the team's SPI_master. It oversamples sclk, cs and mosi on the local clk and shifts DATA_W-bit words MSB-first in both directions. Received words go to the local fabric with a one-cycle valid strobe. Transmit words come from the fabric through a one-entry valid/ready holding buffer.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_slave_if.sv | 42 ++++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Types and constants that the SPI slave shares with SPI_master: the FSM state
// encoding, the default word length and the SPI mode (mode 0).
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  // Mode 0: sclk idles low, data is sampled on the rising edge and changed on
  // the falling edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// Bundle of the SPI pins and the fabric-side transmit/receive signals.
//
// Handshake rules:
//   tx: a word moves from tx_data into the holding buffer on every clk where
//       tx_valid && tx_ready. tx_ready is high exactly when the buffer is
//       empty. tx_data is ignored while tx_valid is low.
//   rx: rx_valid is a one-clk strobe with no backpressure; rx_data holds the
//       last complete word until the next one overwrites it.
// dbg_state / dbg_bit_cnt expose the FSM for observation only.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);

  logic                             sclk;
  logic                             cs;
  logic                             mosi;
  logic                             miso;
  logic [DATA_W-1:0]                tx_data;
  logic                             tx_valid;
  logic                             tx_ready;
  logic [DATA_W-1:0]                rx_data;
  logic                             rx_valid;
  logic                             tx_underrun;
  logic                             busy;
  spi_state_t                       dbg_state;
  logic [$clog2(DATA_W+1)-1:0]      dbg_bit_cnt;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy,
           dbg_state, dbg_bit_cnt
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy,
           dbg_state, dbg_bit_cnt
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, plus single-clk rise and
// fall pulses taken against one extra registered copy of the synchronized level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchronizer chain and keep the previous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave. sclk, cs and mosi are oversampled on clk; words are shifted
// MSB first in both directions. A one-entry holding buffer feeds the transmit
// shifter at each word start; an empty buffer at word start sends zeros and
// raises a one-clk tx_underrun strobe.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  spi_slave_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // Synchronized pins and edge pulses
  logic w_sclk_level_unused;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_level;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;
  logic w_sample_edge;
  logic w_shift_edge;

  // Registered state
  spi_state_t        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift_rx;
  logic [DATA_W-1:0] r_shift_tx;
  logic              r_miso;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_tx_underrun;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_full;

  // Next-state values
  spi_state_t        w_state_n;
  logic [CNT_W-1:0]  w_bit_cnt_n;
  logic [DATA_W-1:0] w_shift_rx_n;
  logic [DATA_W-1:0] w_shift_tx_n;
  logic              w_miso_n;
  logic [DATA_W-1:0] w_rx_data_n;
  logic              w_rx_valid_n;
  logic              w_tx_underrun_n;
  logic [DATA_W-1:0] w_buf_n;
  logic              w_buf_full_n;
  logic              w_load;
  logic              w_tx_ready;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.sclk),
    .o_level (w_sclk_level_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.cs),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // mosi only needs the same synchronizer delay as sclk so the sampled bit
  // lines up with the detected rising edge; its edge pulses are not used.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.mosi),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  // In mode 0 the leading (rising) edge samples and the trailing edge shifts.
  assign w_sample_edge = (SPI_CPOL == SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
  assign w_shift_edge  = (SPI_CPOL == SPI_CPHA) ? w_sclk_fall : w_sclk_rise;

  assign w_tx_ready = ~r_buf_full;

  // Next-state, shifter and buffer logic; cs rising overrides everything else.
  always_comb begin
    w_state_n       = r_state;
    w_bit_cnt_n     = r_bit_cnt;
    w_shift_rx_n    = r_shift_rx;
    w_shift_tx_n    = r_shift_tx;
    w_miso_n        = r_miso;
    w_rx_data_n     = r_rx_data;
    w_rx_valid_n    = 1'b0;
    w_tx_underrun_n = 1'b0;
    w_buf_n         = r_buf;
    w_buf_full_n    = r_buf_full;
    w_load          = 1'b0;

    if (w_cs_rise) begin
      // Frame ended: any partial word is dropped.
      w_state_n   = IDLE;
      w_bit_cnt_n = '0;
      w_miso_n    = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_miso_n    = 1'b0;
          w_bit_cnt_n = '0;
          if (w_cs_fall) begin
            w_state_n = LOAD;
          end
        end
        LOAD: begin
          w_load    = 1'b1;
          w_state_n = SHIFT;
        end
        SHIFT: begin
          if (w_sample_edge) begin
            w_shift_rx_n = {r_shift_rx[DATA_W-2:0], w_mosi};
            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
              w_rx_data_n  = {r_shift_rx[DATA_W-2:0], w_mosi};
              w_rx_valid_n = 1'b1;
              w_bit_cnt_n  = '0;
            end else begin
              w_bit_cnt_n = r_bit_cnt + 1'b1;
            end
          end else if (w_shift_edge) begin
            if (r_bit_cnt == '0) begin
              // Trailing edge after a completed word starts the next word.
              w_load = 1'b1;
            end else begin
              w_shift_tx_n = {r_shift_tx[DATA_W-2:0], 1'b0};
              w_miso_n     = r_shift_tx[DATA_W-2];
            end
          end
        end
        default: begin
          w_state_n = IDLE;
        end
      endcase
    end

    // Word start: take the buffered word, or send zeros and flag underrun.
    if (w_load) begin
      if (r_buf_full) begin
        w_shift_tx_n = r_buf;
        w_miso_n     = r_buf[DATA_W-1];
        w_buf_full_n = 1'b0;
      end else begin
        w_shift_tx_n    = '0;
        w_miso_n        = 1'b0;
        w_tx_underrun_n = 1'b1;
      end
    end

    // Fabric write into the holding buffer; only possible while it is empty,
    // so it never collides with a load that drains a full buffer.
    if (bus.tx_valid && w_tx_ready) begin
      w_buf_n      = bus.tx_data;
      w_buf_full_n = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Shifters, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt     <= '0;
      r_shift_rx    <= '0;
      r_shift_tx    <= '0;
      r_miso        <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_bit_cnt     <= w_bit_cnt_n;
      r_shift_rx    <= w_shift_rx_n;
      r_shift_tx    <= w_shift_tx_n;
      r_miso        <= w_miso_n;
      r_rx_data     <= w_rx_data_n;
      r_rx_valid    <= w_rx_valid_n;
      r_tx_underrun <= w_tx_underrun_n;
    end
  end

  // One-entry transmit holding buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      r_buf      <= w_buf_n;
      r_buf_full <= w_buf_full_n;
    end
  end

  assign bus.miso        = r_miso;
  assign bus.tx_ready    = w_tx_ready;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.busy        = ~w_cs_level;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_bit_cnt = r_bit_cnt;

endmodule
